// File: rtl/tw_table_seq_pkg.sv
// Shared definitions for the twiddle table sequencer: half-word write
// encodings and the identity-twiddle constructor.
package tw_table_seq_pkg;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_HI   = 2'b01;
  localparam logic [1:0] WR_LO   = 2'b10;

  localparam int MAX_P_WIDTH = 1024;

  // IDENT = {HALF_W'h1, HALF_W'h1}; callers truncate to their own word width.
  function automatic logic [MAX_P_WIDTH-1:0] ident_word(input int half_w);
    return MAX_P_WIDTH'(1) | (MAX_P_WIDTH'(1) << half_w);
  endfunction

endpackage

// File: rtl/tw_table_seq_cnt.sv
// Cascaded rep/idx/pass/grp read counter; clr zeroes everything and wins over adv.
module tw_seq_cnt #(
  parameter int REP_W = 4,
  parameter int GW    = 2,
  parameter int IW    = 2,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [REP_W-1:0] cfg_rep,
  input  logic [REP_W-1:0] cfg_grp_rep,
  input  logic [GW-1:0]    cfg_groups,
  output logic [IW-1:0]    idx_cnt,
  output logic [GW-1:0]    grp_cnt
);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] pass_cnt;
  logic             rep_wrap;
  logic             idx_wrap;
  logic             pass_wrap;
  logic             grp_wrap;

  assign rep_wrap  = rep_cnt >= cfg_rep;
  assign idx_wrap  = rep_wrap && (idx_cnt == IW'(DEPTH - 1));
  assign pass_wrap = idx_wrap && (pass_cnt >= cfg_grp_rep);
  assign grp_wrap  = pass_wrap && (grp_cnt >= cfg_groups);

  always_ff @(posedge CLK) begin
    if (!rst_n || clr) begin
      rep_cnt  <= '0;
      idx_cnt  <= '0;
      pass_cnt <= '0;
      grp_cnt  <= '0;
    end else if (adv) begin
      rep_cnt <= rep_wrap ? '0 : rep_cnt + 1'b1;
      if (rep_wrap) begin
        idx_cnt <= idx_wrap ? '0 : idx_cnt + 1'b1;
      end
      if (idx_wrap) begin
        pass_cnt <= pass_wrap ? '0 : pass_cnt + 1'b1;
      end
      // The group counter loops forever; a stage runs until the stage changes.
      if (pass_wrap) begin
        grp_cnt <= grp_wrap ? '0 : grp_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tw_table_seq.sv
// Writable per-stage twiddle table with programmable group/repeat read
// sequencing, stage constants, and a write-stream bypass onto Q.
module tw_table_seq
  import tw_table_seq_pkg::*;
#(
  parameter int P_WIDTH    = 128,
  parameter int NUM_STAGES = 4,
  parameter int MAX_GROUPS = 4,
  parameter int DEPTH      = 4,
  parameter int SC_WIDTH   = 3,
  parameter int REP_W      = 4,
  parameter int BYP_DELAY  = 12,
  parameter logic [P_WIDTH-1:0] IDENT = P_WIDTH'(ident_word(P_WIDTH / 2)),
  localparam int HALF_W = P_WIDTH / 2,
  localparam int GW     = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1,
  localparam int SW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                CEN,
  input  logic [SC_WIDTH-1:0] stage_counter,
  input  logic                step,
  input  logic [GW-1:0]       cfg_groups,
  input  logic [REP_W-1:0]    cfg_rep,
  input  logic [REP_W-1:0]    cfg_grp_rep,
  input  logic [1:0]          wr_half,
  input  logic                wr_const,
  input  logic [SW-1:0]       wr_stage,
  input  logic [GW-1:0]       wr_group,
  input  logic [IW-1:0]       wr_idx,
  input  logic [HALF_W-1:0]   wr_data,
  input  logic                byp_en,
  output logic [P_WIDTH-1:0]  Q,
  output logic                Q_valid,
  output logic [P_WIDTH-1:0]  Q_const
);

  localparam logic [SC_WIDTH:0] NUM_STAGES_SC = (SC_WIDTH + 1)'(NUM_STAGES);
  localparam logic [SW:0]       NUM_STAGES_W  = (SW + 1)'(NUM_STAGES);
  localparam logic [GW:0]       MAX_GROUPS_W  = (GW + 1)'(MAX_GROUPS);
  localparam logic [IW:0]       DEPTH_W       = (IW + 1)'(DEPTH);

  logic [P_WIDTH-1:0] tbl [NUM_STAGES][MAX_GROUPS][DEPTH];
  logic [P_WIDTH-1:0] cst [NUM_STAGES];

  // Stage tracking and configuration
  logic [SC_WIDTH-1:0] stage_q;
  logic                first_q;
  logic [REP_W-1:0]    cfg_rep_q;
  logic [REP_W-1:0]    cfg_grp_rep_q;
  logic [GW-1:0]       cfg_groups_q;
  logic                stage_change;
  logic                load_cfg;
  logic                stage_ok;
  logic [SW-1:0]       stage_idx;
  logic [REP_W-1:0]    rep_eff;
  logic [REP_W-1:0]    grp_rep_eff;
  logic [GW-1:0]       groups_eff;

  // Read sequencing
  logic          cnt_clr;
  logic          cnt_adv;
  logic [IW-1:0] idx_cnt;
  logic [GW-1:0] grp_cnt;
  logic [IW-1:0] rd_idx;
  logic [GW-1:0] rd_grp;
  logic [P_WIDTH-1:0] q_r;
  logic               q_valid_r;
  logic [P_WIDTH-1:0] q_const_r;

  // Write pipe and bypass
  logic [1:0]        wr_half_q;
  logic              wr_const_q;
  logic [SW-1:0]     wr_stage_q;
  logic [GW-1:0]     wr_group_q;
  logic [IW-1:0]     wr_idx_q;
  logic [HALF_W-1:0] wr_data_q;
  logic              wr_commit;
  logic [HALF_W:0]   byp_pipe [BYP_DELAY];
  logic [P_WIDTH-1:0] byp_word;

  assign stage_change = stage_counter != stage_q;
  assign load_cfg     = first_q | stage_change;
  assign stage_ok     = {1'b0, stage_counter} < NUM_STAGES_SC;
  assign stage_idx    = stage_counter[SW-1:0];

  // Counting on the cfg-load cycle must already use the freshly sampled values.
  assign rep_eff     = load_cfg ? cfg_rep     : cfg_rep_q;
  assign grp_rep_eff = load_cfg ? cfg_grp_rep : cfg_grp_rep_q;
  assign groups_eff  = load_cfg ? cfg_groups  : cfg_groups_q;

  assign cnt_clr = stage_change | ~stage_ok;
  assign cnt_adv = ~CEN & step & stage_ok;
  assign rd_idx  = stage_change ? '0 : idx_cnt;
  assign rd_grp  = stage_change ? '0 : grp_cnt;

  tw_seq_cnt #(
    .REP_W (REP_W),
    .GW    (GW),
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_cnt (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .clr         (cnt_clr),
    .adv         (cnt_adv),
    .cfg_rep     (rep_eff),
    .cfg_grp_rep (grp_rep_eff),
    .cfg_groups  (groups_eff),
    .idx_cnt     (idx_cnt),
    .grp_cnt     (grp_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      stage_q       <= '0;
      first_q       <= 1'b1;
      cfg_rep_q     <= '0;
      cfg_grp_rep_q <= '0;
      cfg_groups_q  <= '0;
      q_r           <= IDENT;
      q_valid_r     <= 1'b0;
      q_const_r     <= IDENT;
    end else begin
      stage_q <= stage_counter;
      first_q <= 1'b0;
      if (load_cfg) begin
        cfg_rep_q     <= cfg_rep;
        cfg_grp_rep_q <= cfg_grp_rep;
        cfg_groups_q  <= cfg_groups;
      end
      // Q_valid: high for exactly one cycle per stepped entry; there is no
      // back-pressure, the consumer must take Q in the cycle Q_valid is high.
      if (CEN || !stage_ok) begin
        q_r       <= IDENT;
        q_valid_r <= 1'b0;
      end else begin
        q_r       <= tbl[stage_idx][rd_grp][rd_idx];
        q_valid_r <= step;
        q_const_r <= cst[stage_idx];
      end
    end
  end

  assign wr_commit = ((wr_half_q == WR_HI) || (wr_half_q == WR_LO)) &&
                     ({1'b0, wr_stage_q} < NUM_STAGES_W) &&
                     (wr_const_q || (({1'b0, wr_group_q} < MAX_GROUPS_W) &&
                                     ({1'b0, wr_idx_q} < DEPTH_W)));

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      wr_half_q  <= WR_NONE;
      wr_const_q <= 1'b0;
      wr_stage_q <= '0;
      wr_group_q <= '0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_half_q  <= wr_half;
      wr_const_q <= wr_const;
      wr_stage_q <= wr_stage;
      wr_group_q <= wr_group;
      wr_idx_q   <= wr_idx;
      wr_data_q  <= wr_data;
    end
  end

  // Reads on the commit edge see the old word because both use the same edge.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        cst[s] <= IDENT;
        for (int g = 0; g < MAX_GROUPS; g++) begin
          for (int i = 0; i < DEPTH; i++) begin
            tbl[s][g][i] <= IDENT;
          end
        end
      end
    end else if (wr_commit) begin
      if (wr_const_q) begin
        if (wr_half_q == WR_HI) cst[wr_stage_q][P_WIDTH-1:HALF_W] <= wr_data_q;
        else                    cst[wr_stage_q][HALF_W-1:0]       <= wr_data_q;
      end else begin
        if (wr_half_q == WR_HI) tbl[wr_stage_q][wr_group_q][wr_idx_q][P_WIDTH-1:HALF_W] <= wr_data_q;
        else                    tbl[wr_stage_q][wr_group_q][wr_idx_q][HALF_W-1:0]       <= wr_data_q;
      end
    end
  end

  // Each bypass stage carries {was_lower_write, data}.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int k = 0; k < BYP_DELAY; k++) begin
        byp_pipe[k] <= '0;
      end
    end else begin
      byp_pipe[0] <= {wr_half_q == WR_LO, wr_data_q};
      for (int k = 1; k < BYP_DELAY; k++) begin
        byp_pipe[k] <= byp_pipe[k-1];
      end
    end
  end

  assign byp_word = {(wr_half_q == WR_HI) ? wr_data_q : {HALF_W{1'b0}},
                     byp_pipe[BYP_DELAY-1][HALF_W] ? byp_pipe[BYP_DELAY-1][HALF_W-1:0]
                                                   : {HALF_W{1'b0}}};

  assign Q       = byp_en ? byp_word : q_r;
  assign Q_valid = ~byp_en & q_valid_r;
  assign Q_const = q_const_r;

endmodule

// File: tb/tb_tw_table_seq.sv
// Bench for tw_table_seq: directed scenarios with literal expectations plus a
// randomized run, all checked against a sequence-position reference model.
module tb_tw_table_seq;

  localparam int P_WIDTH    = 128;
  localparam int HALF_W     = 64;
  localparam int NUM_STAGES = 4;
  localparam int MAX_GROUPS = 4;
  localparam int DEPTH      = 4;
  localparam int SC_WIDTH   = 3;
  localparam int REP_W      = 4;
  localparam int BYP_DELAY  = 12;
  localparam logic [P_WIDTH-1:0] IDENT = {64'h1, 64'h1};

  // Clock / reset / DUT
  logic                CLK = 1'b0;
  logic                rst_n;
  logic                CEN;
  logic [SC_WIDTH-1:0] stage_counter;
  logic                step;
  logic [1:0]          cfg_groups;
  logic [REP_W-1:0]    cfg_rep;
  logic [REP_W-1:0]    cfg_grp_rep;
  logic [1:0]          wr_half;
  logic                wr_const;
  logic [1:0]          wr_stage;
  logic [1:0]          wr_group;
  logic [1:0]          wr_idx;
  logic [HALF_W-1:0]   wr_data;
  logic                byp_en;
  logic [P_WIDTH-1:0]  Q;
  logic                Q_valid;
  logic [P_WIDTH-1:0]  Q_const;

  always #5 CLK = ~CLK;

  tw_table_seq dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .CEN           (CEN),
    .stage_counter (stage_counter),
    .step          (step),
    .cfg_groups    (cfg_groups),
    .cfg_rep       (cfg_rep),
    .cfg_grp_rep   (cfg_grp_rep),
    .wr_half       (wr_half),
    .wr_const      (wr_const),
    .wr_stage      (wr_stage),
    .wr_group      (wr_group),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .byp_en        (byp_en),
    .Q             (Q),
    .Q_valid       (Q_valid),
    .Q_const       (Q_const)
  );

  // Scoreboard counters and checks
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [P_WIDTH-1:0] act,
                       input logic [P_WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [P_WIDTH-1:0] pk(input int hi, input int lo);
    return {HALF_W'(hi), HALF_W'(lo)};
  endfunction

  // Reference model: sequence position arithmetic plus a history of write inputs
  typedef struct packed {
    logic [1:0]        half;
    logic              cst;
    logic [1:0]        stage;
    logic [1:0]        grp;
    logic [1:0]        idx;
    logic [HALF_W-1:0] data;
  } wr_rec_t;

  wr_rec_t            hist[$];
  logic [P_WIDTH-1:0] m_tbl [NUM_STAGES][MAX_GROUPS][DEPTH];
  logic [P_WIDTH-1:0] m_const [NUM_STAGES];
  logic [P_WIDTH-1:0] m_q;
  logic [P_WIDTH-1:0] m_qc;
  logic               m_v;
  int  m_pos, m_stage_q, m_rep, m_grp_rep, m_groups;
  bit  m_first;
  bit  model_live = 0;

  task automatic model_reset();
    for (int s = 0; s < NUM_STAGES; s++) begin
      m_const[s] = IDENT;
      for (int g = 0; g < MAX_GROUPS; g++)
        for (int i = 0; i < DEPTH; i++) m_tbl[s][g][i] = IDENT;
    end
    hist.delete();
    for (int k = 0; k <= BYP_DELAY; k++) hist.push_back('0);
    m_pos = 0; m_stage_q = 0; m_first = 1;
    m_rep = 0; m_grp_rep = 0; m_groups = 0;
    m_q = IDENT; m_qc = IDENT; m_v = 1'b0;
    model_live = 1;
  endtask

  always @(posedge CLK) begin
    wr_rec_t cur;
    wr_rec_t old;
    int s, period, e_grp, e_idx;
    bit sc;
    cur.half = wr_half; cur.cst = wr_const; cur.stage = wr_stage;
    cur.grp = wr_group; cur.idx = wr_idx; cur.data = wr_data;
    if (!rst_n) begin
      model_reset();
    end else begin
      s  = int'(stage_counter);
      sc = (s != m_stage_q);
      if (m_first || sc) begin
        m_rep = int'(cfg_rep); m_grp_rep = int'(cfg_grp_rep); m_groups = int'(cfg_groups);
      end
      period = (m_rep + 1) * DEPTH * (m_grp_rep + 1) * (m_groups + 1);
      if (s >= NUM_STAGES) begin
        m_q = IDENT; m_v = 1'b0; m_pos = 0;
      end else begin
        if (sc) m_pos = 0;
        if (CEN) begin
          m_q = IDENT; m_v = 1'b0;
        end else begin
          e_grp = m_pos / ((m_rep + 1) * DEPTH * (m_grp_rep + 1));
          e_idx = (m_pos / (m_rep + 1)) % DEPTH;
          m_q  = m_tbl[s][e_grp][e_idx];
          m_v  = step;
          m_qc = m_const[s];
          if (step && !sc) m_pos = (m_pos + 1) % period;
        end
      end
      old = hist[0];
      if (old.half == 2'b01 || old.half == 2'b10) begin
        if (old.cst) begin
          if (old.half == 2'b01) m_const[old.stage][P_WIDTH-1:HALF_W] = old.data;
          else                   m_const[old.stage][HALF_W-1:0]       = old.data;
        end else begin
          if (old.half == 2'b01) m_tbl[old.stage][old.grp][old.idx][P_WIDTH-1:HALF_W] = old.data;
          else                   m_tbl[old.stage][old.grp][old.idx][HALF_W-1:0]       = old.data;
        end
      end
      hist.push_front(cur);
      void'(hist.pop_back());
      m_stage_q = s;
      m_first   = 0;
    end
  end

  function automatic logic [P_WIDTH-1:0] model_byp();
    logic [HALF_W-1:0] hi, lo;
    hi = (hist[0].half == 2'b01) ? hist[0].data : '0;
    lo = (hist[BYP_DELAY].half == 2'b10) ? hist[BYP_DELAY].data : '0;
    return {hi, lo};
  endfunction

  // Compare process: every cycle, away from the active edge
  always @(negedge CLK) begin
    if (model_live) begin
      check("Q", Q, byp_en ? model_byp() : m_q);
      check1("Q_valid", Q_valid, byp_en ? 1'b0 : m_v);
      check("Q_const", Q_const, m_qc);
    end
  end

  // Driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic write_half(input logic [1:0] half, input bit cst, input int s,
                            input int g, input int i, input logic [HALF_W-1:0] d);
    wr_half = half; wr_const = cst; wr_stage = 2'(s); wr_group = 2'(g);
    wr_idx = 2'(i); wr_data = d;
    tick();
    wr_half = 2'b00;
  endtask

  task automatic set_stage(input int s, input int rep, input int grp_rep, input int groups);
    stage_counter = SC_WIDTH'(s); cfg_rep = REP_W'(rep);
    cfg_grp_rep = REP_W'(grp_rep); cfg_groups = 2'(groups);
  endtask

  logic [HALF_W-1:0] a_word, b_word;

  initial begin
    rst_n = 1'b0; CEN = 1'b0; step = 1'b1; byp_en = 1'b0;
    set_stage(0, 0, 0, 0);
    wr_half = 2'b00; wr_const = 1'b0; wr_stage = '0; wr_group = '0; wr_idx = '0; wr_data = '0;
    tick(3);
    rst_n = 1'b1;
    check1("reset_valid", Q_valid, 1'b0);
    check("reset_q", Q, IDENT);
    check("reset_const", Q_const, IDENT);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ident_q", Q, IDENT);
      check1("ident_valid", Q_valid, 1'b1);
    end

    // Load stage 1 group 0 with {k, k+16}
    for (int k = 0; k < 4; k++) begin
      write_half(2'b01, 0, 1, 0, k, HALF_W'(k));
      write_half(2'b10, 0, 1, 0, k, HALF_W'(k + 16));
    end
    tick(2);
    set_stage(1, 1, 0, 0);
    tick();
    check("seq_start", Q, pk(0, 16));
    for (int n = 0; n < 16; n++) begin
      tick();
      check("seq_rep1", Q, pk((n / 2) % 4, (n / 2) % 4 + 16));
    end

    // Group 1 gets {k+100, k+200}; run two groups, two passes each
    for (int k = 0; k < 4; k++) begin
      write_half(2'b01, 0, 1, 1, k, HALF_W'(k + 100));
      write_half(2'b10, 0, 1, 1, k, HALF_W'(k + 200));
    end
    tick(2);
    set_stage(2, 0, 0, 0);
    tick();
    set_stage(1, 0, 1, 1);
    tick();
    check("grp_start", Q, pk(0, 16));
    for (int n = 0; n <= 16; n++) begin
      tick();
      check("grp_seq", Q, ((n / 8) % 2 == 0) ? pk(n % 4, n % 4 + 16)
                                             : pk(n % 4 + 100, n % 4 + 200));
    end

    // Pause mid-group, then resume
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("pause_valid", Q_valid, 1'b0);
      check("pause_q", Q, pk(1, 17));
    end
    step = 1'b1;
    tick();
    check("resume_q", Q, pk(1, 17));
    tick();
    check("resume_next", Q, pk(2, 18));
    set_stage(0, 0, 0, 0);
    tick();
    check("stage_change_q", Q, IDENT);

    // Read/write collision on the entry being shown
    set_stage(1, 15, 0, 0);
    tick();
    check("collide_start", Q, pk(0, 16));
    write_half(2'b01, 0, 1, 0, 0, HALF_W'(55));
    tick();
    check("collide_old", Q, pk(0, 16));
    tick();
    check("collide_new", Q, pk(55, 16));
    write_half(2'b11, 0, 1, 0, 0, HALF_W'(77));
    tick(2);
    check("half11_ignored", Q, pk(55, 16));

    // Bypass timing
    byp_en = 1'b1;
    tick(BYP_DELAY + 2);
    check("byp_idle", Q, '0);
    a_word = 64'hA5A5_0000_1234_5678;
    b_word = 64'h0F0F_CAFE_0000_0042;
    write_half(2'b01, 0, 2, 0, 0, a_word);
    check("byp_hi", Q, {a_word, 64'h0});
    check1("byp_valid", Q_valid, 1'b0);
    write_half(2'b10, 0, 2, 0, 1, b_word);
    tick(BYP_DELAY - 1);
    write_half(2'b01, 0, 2, 0, 2, a_word);
    check("byp_both", Q, {a_word, b_word});
    tick();
    check("byp_drain", Q, '0);
    byp_en = 1'b0;

    // Randomized run
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0)
        stage_counter = ($urandom_range(0, 9) < 8) ? SC_WIDTH'($urandom_range(0, 3))
                                                   : SC_WIDTH'($urandom_range(4, 7));
      CEN         = ($urandom_range(0, 9) == 0);
      step        = ($urandom_range(0, 5) != 0);
      cfg_rep     = REP_W'($urandom_range(0, 3));
      cfg_grp_rep = REP_W'($urandom_range(0, 2));
      cfg_groups  = 2'($urandom_range(0, 3));
      wr_half     = 2'($urandom_range(0, 3));
      wr_const    = ($urandom_range(0, 7) == 0);
      wr_stage    = 2'($urandom_range(0, 3));
      wr_group    = 2'($urandom_range(0, 3));
      wr_idx      = 2'($urandom_range(0, 3));
      wr_data     = {$urandom(), $urandom()};
      if ($urandom_range(0, 99) == 0) byp_en = ~byp_en;
      tick();
    end
    byp_en = 1'b0; rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
